// File: rtl/clk_div_mon_if.sv
// Monitor-side bundle for clk_div_mon: divided clock and enable in,
// lock/measurement/error reporting out.
interface clk_div_mon_if #(
  parameter int CNT_W = 8
);
  logic             i_div_clk;
  logic             i_en;
  logic             o_locked;
  logic             o_meas_vld;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic             o_err;

  // Stimulus / consumer side.
  modport master (
    output i_div_clk, i_en,
    input  o_locked, o_meas_vld, o_period, o_high, o_err
  );

  // Monitor side.
  modport slave (
    input  i_div_clk, i_en,
    output o_locked, o_meas_vld, o_period, o_high, o_err
  );
endinterface

// File: rtl/clk_div_mon.sv
// Divided-clock monitor: measures period/high time of i_div_clk in i_clk cycles,
// tracks lock against DIV_N. Optional CLK_DIV_MON_SYNC_EN adds a 2-flop synchronizer.
module clk_div_mon #(
  parameter int DIV_N    = 5,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  clk_div_mon_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  PER_GOOD = CNT_W'(DIV_N);
  localparam logic [CNT_W-1:0]  HIGH_LO  = CNT_W'(DIV_N / 2);
  localparam logic [CNT_W-1:0]  HIGH_HI  = CNT_W'((DIV_N + 1) / 2);
  localparam logic [CNT_W-1:0]  TIMEOUT  = CNT_W'(2 * DIV_N);
  localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_CNT);

  // ---------------------------------------------------------------------------
  // Sample path
  // ---------------------------------------------------------------------------
  logic s_in;

`ifdef CLK_DIV_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], bus.i_div_clk};
  end

  assign s_in = sync_q[1];
`else
  assign s_in = bus.i_div_clk;
`endif

  logic s_q;
  logic s_d;

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_q <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s_q <= s_in;
      s_d <= s_q;
    end
  end

  logic rise;
  assign rise = s_q & ~s_d;

  // ---------------------------------------------------------------------------
  // State and measurement registers
  // ---------------------------------------------------------------------------
  state_t            state,      state_n;
  logic [CNT_W-1:0]  per_cnt,    per_cnt_n;
  logic [CNT_W-1:0]  high_cnt,   high_cnt_n;
  logic [GOOD_W-1:0] good_cnt,   good_cnt_n;
  logic [CNT_W-1:0]  period_q,   period_n;
  logic [CNT_W-1:0]  high_q,     high_n;
  logic              meas_vld_q, meas_vld_n;
  logic              err_q,      err_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      per_cnt    <= '0;
      high_cnt   <= '0;
      good_cnt   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      meas_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      per_cnt    <= per_cnt_n;
      high_cnt   <= high_cnt_n;
      good_cnt   <= good_cnt_n;
      period_q   <= period_n;
      high_q     <= high_n;
      meas_vld_q <= meas_vld_n;
      err_q      <= err_n;
    end
  end

  // A measurement is only meaningful in the rise cycle, where the counters
  // hold the full window ending at this rise.
  logic meas_good;
  logic timeout;

  assign meas_good = (per_cnt == PER_GOOD) &&
                     ((high_cnt == HIGH_LO) || (high_cnt == HIGH_HI));
  assign timeout   = (per_cnt == TIMEOUT);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_n    = state;
    per_cnt_n  = per_cnt;
    high_cnt_n = high_cnt;
    good_cnt_n = good_cnt;
    period_n   = period_q;
    high_n     = high_q;
    meas_vld_n = 1'b0;
    err_n      = 1'b0;

    if (!bus.i_en) begin
      state_n    = ST_IDLE;
      per_cnt_n  = '0;
      high_cnt_n = '0;
      good_cnt_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n    = ST_ARM;
          per_cnt_n  = '0;
          high_cnt_n = '0;
          good_cnt_n = '0;
        end

        ST_ARM: begin
          if (rise) begin
            per_cnt_n  = CNT_W'(1);
            high_cnt_n = CNT_W'(1);
            good_cnt_n = '0;
            state_n    = ST_TRACK;
          end
        end

        ST_TRACK, ST_LOCKED: begin
          if (rise) begin
            // The rise cycle itself is high, so both windows restart at 1.
            per_cnt_n  = CNT_W'(1);
            high_cnt_n = CNT_W'(1);
            period_n   = per_cnt;
            high_n     = high_cnt;
            meas_vld_n = 1'b1;
            if (meas_good) begin
              if (state == ST_TRACK) begin
                good_cnt_n = good_cnt + GOOD_W'(1);
                if (good_cnt + GOOD_W'(1) == LOCK_V) state_n = ST_LOCKED;
              end
            end else begin
              good_cnt_n = '0;
              err_n      = 1'b1;
              state_n    = ST_TRACK;
            end
          end else if (timeout) begin
            err_n      = 1'b1;
            state_n    = ST_ARM;
            per_cnt_n  = '0;
            high_cnt_n = '0;
            good_cnt_n = '0;
          end else begin
            per_cnt_n  = per_cnt + CNT_W'(1);
            high_cnt_n = high_cnt + CNT_W'(s_q);
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.o_locked   = (state == ST_LOCKED);
  assign bus.o_meas_vld = meas_vld_q;
  assign bus.o_period   = period_q;
  assign bus.o_high     = high_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_clk_div_mon.sv
// Self-checking bench for clk_div_mon: directed scenarios plus random periods,
// gaps and enable toggles, checked every cycle against an event-level model.
module tb_clk_div_mon;

  localparam int DIV_N    = 5;
  localparam int LOCK_CNT = 4;
  localparam int CNT_W    = 8;
`ifdef CLK_DIV_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;

  clk_div_mon_if #(.CNT_W(CNT_W)) bus ();

  clk_div_mon #(
    .DIV_N    (DIV_N),
    .LOCK_CNT (LOCK_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works on the edge numbers at which i_div_clk was sampled
  // high/low, deriving periods as differences between rise edges.
  // ---------------------------------------------------------------------------
  typedef enum int {M_OFF, M_WAIT, M_COUNT, M_LOCK} mode_t;

  bit    hist [4096];
  int    edge_no   = 0;
  int    rst_floor = 0;
  mode_t mode      = M_OFF;
  int    last_rise = 0;
  int    good_run  = 0;
  int    exp_period = 0;
  int    exp_high   = 0;
  bit    exp_vld    = 0;
  bit    exp_err    = 0;

  function automatic bit sample_at(input int idx);
    if (idx <= rst_floor || idx < 0) return 1'b0;
    return hist[idx % 4096];
  endfunction

  always @(posedge clk) begin
    int  r;
    int  p;
    int  h;
    bit  rise;
    bit  good;
    edge_no++;
    hist[edge_no % 4096] = bus.i_div_clk;
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (!rst_n) begin
      rst_floor  = edge_no;
      mode       = M_OFF;
      good_run   = 0;
      exp_period = 0;
      exp_high   = 0;
    end else begin
      r    = edge_no - 1 - LAT;
      rise = sample_at(r) && !sample_at(r - 1);
      if (!bus.i_en) begin
        mode     = M_OFF;
        good_run = 0;
      end else begin
        case (mode)
          M_OFF:  mode = M_WAIT;
          M_WAIT: if (rise) begin
            mode      = M_COUNT;
            last_rise = r;
            good_run  = 0;
          end
          default: begin
            if (rise) begin
              p = r - last_rise;
              h = 0;
              for (int i = last_rise; i < r; i++) h += int'(sample_at(i));
              exp_period = p;
              exp_high   = h;
              exp_vld    = 1'b1;
              good = (p == DIV_N) && (h == DIV_N / 2 || h == (DIV_N + 1) / 2);
              if (good) begin
                if (mode == M_COUNT) begin
                  good_run++;
                  if (good_run == LOCK_CNT) mode = M_LOCK;
                end
              end else begin
                exp_err  = 1'b1;
                good_run = 0;
                mode     = M_COUNT;
              end
              last_rise = r;
            end else if (r - last_rise == 2 * DIV_N) begin
              exp_err  = 1'b1;
              good_run = 0;
              mode     = M_WAIT;
            end
          end
        endcase
      end
    end
    #1;
    check("meas_vld", bus.o_meas_vld, exp_vld);
    check("err",      bus.o_err,      exp_err);
    check("locked",   bus.o_locked,   mode == M_LOCK);
    check("period",   bus.o_period,   exp_period);
    check("high",     bus.o_high,     exp_high);
    if (bus.o_err === 1'b1) err_seen++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: i_div_clk and i_en change on the falling edge only.
  // ---------------------------------------------------------------------------
  task automatic drive_period(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      bus.i_div_clk = (i < h);
    end
  endtask

  task automatic drive_low(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_div_clk = 1'b0;
    end
  endtask

  task automatic good_periods(input int n);
    for (int i = 0; i < n; i++)
      drive_period(DIV_N, $urandom_range((DIV_N + 1) / 2, DIV_N / 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int p;
    rst_n         = 1'b0;
    bus.i_en      = 1'b0;
    bus.i_div_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_locked", bus.o_locked, 0);
    check("rst_period", bus.o_period, 0);
    bus.i_en = 1'b1;

    // Nominal divider: lock on the 4th good measurement, no errors.
    e0 = err_seen;
    good_periods(6);
    check("s1_locked", bus.o_locked, 1);
    check("s1_errs",   err_seen - e0, 0);

    // Wrong ratio: every measured period flags an error.
    e0 = err_seen;
    for (int i = 0; i < 6; i++) drive_period(7, 3);
    check("s2_locked", bus.o_locked, 0);
    check("s2_errs",   err_seen - e0, 5);

    // Stall while locked -> timeout, then relock after arm + 4 good.
    good_periods(6);
    check("s3_pre_lock", bus.o_locked, 1);
    e0 = err_seen;
    drive_low(12);
    check("s3_to_lock", bus.o_locked, 0);
    check("s3_to_errs", err_seen - e0, 1);
    good_periods(5);
    check("s3_relock", bus.o_locked, 1);

    // Single short period while locked.
    e0 = err_seen;
    drive_period(3, 1);
    good_periods(1);
    check("s4_drop",  bus.o_locked, 0);
    check("s4_errs",  err_seen - e0, 1);
    good_periods(4);
    check("s4_relock", bus.o_locked, 1);

    // Enable dropped mid-period.
    @(negedge clk); bus.i_div_clk = 1'b1;
    @(negedge clk); bus.i_div_clk = 1'b1;
    @(negedge clk); bus.i_en = 1'b0; bus.i_div_clk = 1'b0;
    @(posedge clk); #2;
    check("s5_en_locked", bus.o_locked, 0);
    check("s5_en_vld",    bus.o_meas_vld, 0);
    repeat (3) @(negedge clk);
    bus.i_en = 1'b1;
    good_periods(6);
    check("s5_relock", bus.o_locked, 1);

    // Random mix of good/bad periods, stalls and enable toggles.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(9, 0))
        6: begin
          p = $urandom_range(12, 2);
          drive_period(p, $urandom_range(p - 1, 1));
        end
        7: drive_low($urandom_range(14, 6));
        8: begin
          @(negedge clk); bus.i_en = 1'b0;
          repeat ($urandom_range(4, 1)) @(negedge clk);
          bus.i_en = 1'b1;
        end
        default: good_periods(1);
      endcase
    end

    // Asynchronous reset mid-period.
    good_periods(6);
    @(negedge clk); bus.i_div_clk = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_locked", bus.o_locked,   0);
    check("arst_vld",    bus.o_meas_vld, 0);
    check("arst_err",    bus.o_err,      0);
    check("arst_period", bus.o_period,   0);
    check("arst_high",   bus.o_high,     0);
    @(negedge clk); bus.i_div_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = err_seen;
    good_periods(6);
    check("s6_locked", bus.o_locked, 1);
    check("s6_errs",   err_seen - e0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_mon.md
# clk_div_mon

Divided-clock monitor that sits directly downstream of the Mod-N odd clock divider. It samples the divider output in the source-clock domain and measures period and high time in source-clock cycles. It checks each measurement against the expected ratio and reports lock, per-period measurements and error pulses. The monitor is used in-system and as a self-checking bench companion to the divider.

## Interface
- DIV_N, 5, expected divide ratio; odd or even, ≥ 2.
- LOCK_CNT, 4, consecutive good periods required to assert lock; ≥ 1.
- CNT_W, 8, counter and measurement width; must satisfy 2^CNT_W > 2*DIV_N.
- i_clk  input  1  source clock; the same clock that drives the divider. All logic runs on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_div_clk  input  1  divided clock under test; the divider's o_clk.
- i_en  input  1  monitor enable; level.
- o_locked  output  1  high while LOCK_CNT or more consecutive good periods have been seen.
- o_meas_vld  output  1  one-cycle pulse; o_period and o_high hold a new measurement.
- o_period  output  CNT_W  last measured period, in i_clk cycles.
- o_high  output  CNT_W  last measured high time, in i_clk cycles.
- o_err  output  1  one-cycle pulse on a bad measurement or a timeout.

## Operation
- Sample path: s = i_div_clk registered on i_clk; s_d = s delayed one cycle. A rise is detected in the cycle where s = 1 and s_d = 0.
- Period counter:
  - Loads 1 in the cycle after a rise.
  - Otherwise increments.
  - Its value at the next rise equals the number of i_clk cycles between the two rises.
- High counter: counts the cycles with s = 1 in the same window. It is cleared together with the period counter.
- Good measurement: period == DIV_N and high ∈ {DIV_N/2 floor, DIV_N/2 ceil}.
- States and transitions:
  - IDLE: entered whenever i_en = 0. All counters are cleared. Moves to ARM when i_en = 1.
  - ARM: waits for the first rise. On the rise, clears the counters and moves to TRACK. No measurement is reported.
  - TRACK: every rise latches o_period and o_high and pulses o_meas_vld.
    - Good: good_cnt increments; when it reaches LOCK_CNT, move to LOCKED.
    - Bad: good_cnt = 0 and o_err pulses.
  - LOCKED: o_locked = 1.
    - Good: no change.
    - Bad: o_err pulses, o_locked = 0, good_cnt = 0, move to TRACK.
- Timeout applies in TRACK and LOCKED:
  - Trigger: the period counter reaches 2*DIV_N with no rise.
  - Response: o_err pulses, o_locked = 0, state goes to ARM, counters are cleared, no o_meas_vld.
- i_en low:
  - The monitor enters IDLE on the next edge from any state.
  - o_locked, o_meas_vld and o_err become 0.
  - o_period and o_high hold their values.
- A rise and a timeout in the same cycle: the rise wins and the measurement is evaluated normally.

## Timing
- Reset value: every output and internal register is 0, and the state is IDLE. Reset is asynchronous on assertion and takes effect immediately mid-operation.
- Measurement latency: o_meas_vld, o_period, o_high, o_err and o_locked update at the i_clk edge that ends the rise-detect cycle. This is 2 i_clk edges after i_div_clk rises.
- o_locked rises in the same cycle as the o_meas_vld of the LOCK_CNT-th good period.
- o_locked falls in the same cycle as the o_err pulse.
- A high time that straddles the falling edge of i_clk is counted by its rising-edge samples only. This produces either value of the {floor, ceil} pair, and both are accepted.

## Configuration
- CLK_DIV_MON_SYNC_EN:
  - Defined: a 2-flop synchronizer is inserted ahead of s. All latencies grow by 2 cycles, so measurement latency becomes 4 edges. Use this when i_div_clk is not derived from i_clk.
  - Undefined: a single sampling register as described under Operation.

## Test plan
- Drive i_div_clk from the divider with N=5; i_en=1 after reset → first o_meas_vld carries period=5 and high ∈ {2,3}. o_locked=1 with the 4th good measurement. No o_err.
- Drive i_div_clk at a ratio of 7 with DIV_N=5 → o_meas_vld with period=7 and o_err on every period. o_locked stays 0.
- While locked, hold i_div_clk low → o_err pulses 10 cycles after the last counter load. o_locked=0 and state is ARM. Resume the clock → relock after 1 arming rise plus 4 good periods.
- While locked, inject one 3-cycle period → single o_err with period=3. o_locked drops, then reasserts after 4 good periods.
- Deassert i_en mid-period → the next cycle shows o_locked=0, no pulses, and o_period/o_high unchanged. Reassert → ARM then TRACK.
- Assert i_rst_n low asynchronously mid-period → all outputs 0 immediately. After release, behaviour matches the first scenario.
